// File: rtl/fft_frame_scheduler.sv
// FFT frame scheduler: finds FFFF sync headers, forwards one payload
// frame to the FFT core, then holds off until done or timeout.
module fft_frame_scheduler #(
  parameter int HDR_LEN      = 3,
  parameter int PAYLOAD_LEN  = 10,
  parameter int DONE_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  input  logic        fft_ready,
  input  logic        fft_done,
  output logic [15:0] fft_data,
  output logic        fft_valid,
  output logic        fft_start,
  output logic        fft_last,
  output logic        fft_abort,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic [7:0]  drop_cnt,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    HUNT      = 2'd0,
    PAYLOAD   = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam logic [3:0]  HDR_LAST = 4'(HDR_LEN - 1);
  localparam logic [9:0]  PAY_LAST = 10'(PAYLOAD_LEN - 1);
  localparam logic [9:0]  SKIP_LEN = 10'(PAYLOAD_LEN);
  localparam logic [15:0] TMO_LAST = 16'(DONE_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  hdr_q, hdr_d;
  logic [9:0]  pay_q, pay_d;
  logic [15:0] tmo_q, tmo_d;
  logic [9:0]  skip_q, skip_d;
  logic [15:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        start_q, start_d;
  logic        last_q, last_d;
  logic        abort_q, abort_d;
  logic [15:0] frame_q, frame_d;
  logic [7:0]  drop_q, drop_d;
  logic        terr_q, terr_d;

  logic is_ffff;
  logic hdr_hit;

  // Header completes on the FFFF word that fills the run; the matcher is
  // blind while forwarding a payload or skipping a dropped one.
  assign is_ffff = in_valid && (in_data == 16'hFFFF);
  assign hdr_hit = is_ffff && (hdr_q == HDR_LAST)
                && (skip_q == 10'd0) && (state_q != PAYLOAD);

  // State, matcher, counters and registered FFT outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      hdr_q   <= '0;
      pay_q   <= '0;
      tmo_q   <= '0;
      skip_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      last_q  <= 1'b0;
      abort_q <= 1'b0;
      frame_q <= '0;
      drop_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      pay_q   <= pay_d;
      tmo_q   <= tmo_d;
      skip_q  <= skip_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      start_q <= start_d;
      last_q  <= last_d;
      abort_q <= abort_d;
      frame_q <= frame_d;
      drop_q  <= drop_d;
      terr_q  <= terr_d;
    end
  end

  // Next-state: header matcher plus frame sequencing.
  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    pay_d   = pay_q;
    tmo_d   = tmo_q;
    skip_d  = skip_q;
    data_d  = data_q;
    valid_d = 1'b0;
    start_d = 1'b0;
    last_d  = 1'b0;
    abort_d = 1'b0;
    frame_d = frame_q;
    drop_d  = drop_q;
    terr_d  = terr_q;

    if (state_q == PAYLOAD) begin
      hdr_d = '0;
    end else if (skip_q != 10'd0) begin
      hdr_d = '0;
      if (in_valid) skip_d = skip_q - 10'd1;
    end else if (in_valid) begin
      if (!is_ffff || hdr_hit) hdr_d = '0;
      else                     hdr_d = hdr_q + 4'd1;
    end

    unique case (state_q)
      HUNT: begin
        if (hdr_hit) begin
          state_d = PAYLOAD;
          pay_d   = '0;
        end
      end
      PAYLOAD: begin
        if (in_valid) begin
          if (fft_ready) begin
            valid_d = 1'b1;
            data_d  = in_data;
            start_d = (pay_q == 10'd0);
            last_d  = (pay_q == PAY_LAST);
            if (pay_q == PAY_LAST) begin
              state_d = WAIT_DONE;
              tmo_d   = '0;
            end else begin
              pay_d = pay_q + 10'd1;
            end
          end else begin
            abort_d = 1'b1;
            state_d = HUNT;
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
          end
        end
      end
      WAIT_DONE: begin
        tmo_d = tmo_q + 16'd1;
        if (fft_done) begin
          frame_d = frame_q + 16'd1;
          if (hdr_hit) begin
            state_d = PAYLOAD;
            pay_d   = '0;
          end else begin
            state_d = HUNT;
          end
        end else begin
          if (hdr_hit) begin
            skip_d = SKIP_LEN;
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
          end
          if (tmo_q == TMO_LAST) begin
            terr_d  = 1'b1;
            state_d = HUNT;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  assign fft_data    = data_q;
  assign fft_valid   = valid_q;
  assign fft_start   = start_q;
  assign fft_last    = last_q;
  assign fft_abort   = abort_q;
  assign busy        = (state_q != HUNT);
  assign frame_cnt   = frame_q;
  assign drop_cnt    = drop_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Bench for fft_frame_scheduler: directed scenarios plus random traffic
// checked cycle by cycle against a behavioural frame model.
module tb_fft_frame_scheduler;

  localparam int HDR = 3;
  localparam int PL  = 10;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        fft_ready = 1'b1;
  logic        fft_done = 1'b0;
  logic [15:0] fft_data;
  logic        fft_valid;
  logic        fft_start;
  logic        fft_last;
  logic        fft_abort;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [7:0]  drop_cnt;
  logic        timeout_err;

  fft_frame_scheduler #(
    .HDR_LEN(HDR),
    .PAYLOAD_LEN(PL),
    .DONE_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .fft_ready(fft_ready),
    .fft_done(fft_done),
    .fft_data(fft_data),
    .fft_valid(fft_valid),
    .fft_start(fft_start),
    .fft_last(fft_last),
    .fft_abort(fft_abort),
    .busy(busy),
    .frame_cnt(frame_cnt),
    .drop_cnt(drop_cnt),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // model state: mode 0 = hunting, 1 = forwarding, 2 = waiting on FFT
  int          m_mode, m_run, m_idx, m_skip, m_wait, m_drops;
  logic [15:0] m_frames;
  bit          m_terr;
  bit          e_valid, e_start, e_last, e_abort;
  logic [15:0] e_data;

  logic [15:0] beats[$];
  logic [15:0] start_data, last_data;
  int          n_abort;

  logic [15:0] pend[$];
  logic        v;
  logic [15:0] d;
  int          k;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic mv, input logic [15:0] md,
                            input logic mr, input logic mdn,
                            input logic mrs);
    bit hit;
    e_valid = 0;
    e_start = 0;
    e_last  = 0;
    e_abort = 0;
    if (mrs) begin
      m_mode = 0; m_run = 0; m_idx = 0; m_skip = 0; m_wait = 0;
      m_frames = '0; m_drops = 0; m_terr = 0; e_data = '0;
      return;
    end
    hit = 0;
    if (m_mode != 1) begin
      if (m_skip > 0) begin
        if (mv) m_skip--;
      end else if (mv) begin
        if (md == 16'hFFFF) begin
          m_run++;
          if (m_run == HDR) begin
            hit = 1;
            m_run = 0;
          end
        end else begin
          m_run = 0;
        end
      end
    end
    case (m_mode)
      0: if (hit) begin
        m_mode = 1;
        m_idx = 0;
      end
      1: if (mv) begin
        if (mr) begin
          e_valid = 1;
          e_data  = md;
          e_start = (m_idx == 0);
          e_last  = (m_idx == PL - 1);
          m_idx++;
          if (m_idx == PL) begin
            m_mode = 2;
            m_wait = 0;
          end
        end else begin
          e_abort = 1;
          if (m_drops < 255) m_drops++;
          m_mode = 0;
        end
      end
      default: begin
        if (mdn) begin
          m_frames++;
          m_mode = hit ? 1 : 0;
          m_idx = 0;
        end else begin
          if (hit) begin
            if (m_drops < 255) m_drops++;
            m_skip = PL;
          end
          if (m_wait == TMO - 1) begin
            m_terr = 1;
            m_mode = 0;
          end
          m_wait++;
        end
      end
    endcase
  endtask

  task automatic step(input logic sv, input logic [15:0] sd,
                      input logic sr, input logic sdn, input logic srs);
    in_valid  = sv;
    in_data   = sd;
    fft_ready = sr;
    fft_done  = sdn;
    rst       = srs;
    @(posedge clk);
    model_edge(sv, sd, sr, sdn, srs);
    #1;
    chk("fft_valid", 32'(fft_valid), 32'(e_valid));
    chk("fft_data", 32'(fft_data), 32'(e_data));
    chk("fft_start", 32'(fft_start), 32'(e_start));
    chk("fft_last", 32'(fft_last), 32'(e_last));
    chk("fft_abort", 32'(fft_abort), 32'(e_abort));
    chk("busy", 32'(busy), 32'(m_mode != 0));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    if (fft_valid) beats.push_back(fft_data);
    if (fft_start) start_data = fft_data;
    if (fft_last) last_data = fft_data;
    if (fft_abort) n_abort++;
  endtask

  task automatic wd(input logic [15:0] w);
    step(1'b1, w, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic done_pulse();
    step(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    beats.delete();
    start_data = '0;
    last_data = '0;
    n_abort = 0;
  endtask

  task automatic header();
    for (int i = 0; i < HDR; i++) wd(16'hFFFF);
  endtask

  task automatic frame(input logic [15:0] base);
    header();
    for (int i = 0; i < PL; i++) wd(base + 16'(i));
  endtask

  initial begin
    do_reset();
    chk("rst_valid", 32'(fft_valid), 0);
    chk("rst_busy", 32'(busy), 0);

    // basic frame
    frame(16'h0001);
    idle(4);
    done_pulse();
    idle(1);
    chk("basic_beats", beats.size(), 10);
    chk("basic_first", 32'(beats[0]), 32'h1);
    chk("basic_start", 32'(start_data), 32'h1);
    chk("basic_last", 32'(last_data), 32'hA);
    chk("basic_frames", 32'(frame_cnt), 1);
    chk("basic_busy", 32'(busy), 0);

    // long header with a gap: fourth FFFF is payload word 0
    do_reset();
    wd(16'hFFFF);
    idle(1);
    wd(16'hFFFF);
    wd(16'hFFFF);
    wd(16'hFFFF);
    for (int i = 0; i < PL - 1; i++) wd(16'h0200 + 16'(i));
    done_pulse();
    chk("long_beats", beats.size(), 10);
    chk("long_start", 32'(start_data), 32'hFFFF);
    chk("long_frames", 32'(frame_cnt), 1);

    // broken header produces nothing
    do_reset();
    wd(16'hFFFF);
    wd(16'hFFFF);
    wd(16'h1234);
    wd(16'hFFFF);
    idle(3);
    chk("broken_busy", 32'(busy), 0);
    chk("broken_beats", beats.size(), 0);

    // back-pressure abort on payload word 4
    do_reset();
    header();
    for (int i = 0; i < 4; i++) wd(16'h0300 + 16'(i));
    step(1'b1, 16'h0304, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("bp_beats", beats.size(), 4);
    chk("bp_aborts", n_abort, 1);
    chk("bp_drops", 32'(drop_cnt), 1);
    beats.delete();
    frame(16'h0400);
    done_pulse();
    chk("bp_next_beats", beats.size(), 10);
    chk("bp_next_frames", 32'(frame_cnt), 1);

    // second frame arrives while busy and is dropped
    do_reset();
    frame(16'h0500);
    frame(16'h0600);
    done_pulse();
    idle(2);
    chk("busy_beats", beats.size(), 10);
    chk("busy_drops", 32'(drop_cnt), 1);
    chk("busy_frames", 32'(frame_cnt), 1);

    // timeout with no done
    do_reset();
    frame(16'h0700);
    idle(TMO - 1);
    chk("tmo_early", 32'(timeout_err), 0);
    idle(1);
    chk("tmo_set", 32'(timeout_err), 1);
    chk("tmo_hunt", 32'(busy), 0);
    frame(16'h0800);
    done_pulse();
    chk("tmo_next_frames", 32'(frame_cnt), 1);
    chk("tmo_sticky", 32'(timeout_err), 1);

    // reset in the middle of a payload
    do_reset();
    frame(16'h0900);
    done_pulse();
    header();
    for (int i = 0; i < 5; i++) wd(16'h0A00 + 16'(i));
    step(1'b1, 16'h0A05, 1'b1, 1'b0, 1'b1);
    chk("mr_valid", 32'(fft_valid), 0);
    chk("mr_data", 32'(fft_data), 0);
    chk("mr_abort", 32'(fft_abort), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_frames", 32'(frame_cnt), 0);
    beats.delete();
    frame(16'h0B00);
    done_pulse();
    chk("mr_beats", beats.size(), 10);
    chk("mr_first", 32'(beats[0]), 32'h0B00);
    chk("mr_frames2", 32'(frame_cnt), 1);

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (pend.size() == 0) begin
        k = $urandom_range(0, 3);
        if (k == 0 || k == 3) begin
          for (int i = 0; i < HDR + $urandom_range(0, 1); i++)
            pend.push_back(16'hFFFF);
          for (int i = 0; i < PL; i++)
            pend.push_back(($urandom_range(0, 9) == 0) ?
                           16'hFFFF : 16'($urandom));
        end else if (k == 1) begin
          for (int i = 0; i < $urandom_range(1, 4); i++)
            pend.push_back(16'($urandom));
        end
      end
      v = (pend.size() > 0) && ($urandom_range(0, 4) != 0);
      d = v ? pend.pop_front() : 16'($urandom);
      step(v, d, $urandom_range(0, 29) != 0,
           $urandom_range(0, 11) == 0, $urandom_range(0, 599) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_frame_scheduler.md
Name: fft_frame_scheduler

Overview:
Sequences framed sample traffic into the FFT core. The block hunts the input stream for a sync header of consecutive 16'hFFFF words, then forwards exactly PAYLOAD_LEN payload words to the FFT input with start and last markers. It then holds off further frames until the FFT reports completion or a timeout expires. Frames that arrive while the FFT is busy are dropped and counted, and no partial frame ever reaches the core unflagged.

Parameters:
HDR_LEN, 3, number of consecutive 16'hFFFF words that form a header (range 1..15).
PAYLOAD_LEN, 10, payload words forwarded per frame (range 1..1023).
DONE_TIMEOUT, 4096, maximum cycles in WAIT_DONE before the frame is abandoned (range 1..65535).

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
in_data  in  16  incoming sample stream.
in_valid  in  1  in_data is valid this cycle. The source cannot be stalled.
fft_ready  in  1  FFT core can accept a word this cycle.
fft_done  in  1  single-cycle pulse from the FFT core: the frame has been processed.
fft_data  out  16  registered payload word to the FFT.
fft_valid  out  1  fft_data is valid.
fft_start  out  1  qualifies the first payload word of a frame.
fft_last  out  1  qualifies the PAYLOAD_LEN-th payload word.
fft_abort  out  1  single-cycle pulse: the current frame was truncated and the FFT must discard it.
busy  out  1  high in PAYLOAD and WAIT_DONE.
frame_cnt  out  16  count of completed frames (fft_done received); wraps at 16'hFFFF.
drop_cnt  out  8  count of dropped or aborted frames; saturates at 8'hFF.
timeout_err  out  1  sticky; set on timeout; cleared only by rst.

Behaviour:
Reset:
- On rst, state goes to HUNT.
- All counters clear, and every output is 0, including fft_data.
- rst mid-frame gives no fft_abort pulse. The FFT is reset from the same rst.

Header matcher (runs in every state):
- hdr_cnt increments on each in_valid word equal to 16'hFFFF, saturating at HDR_LEN.
- Any in_valid word not equal to 16'hFFFF clears hdr_cnt.
- Cycles with in_valid low leave hdr_cnt unchanged, so gaps inside a header are allowed.
- A header "completes" on the valid word that brings hdr_cnt to HDR_LEN. hdr_cnt then clears, so a longer run of FFFF can re-trigger.

HUNT:
- On header completion, go to PAYLOAD with pay_cnt = 0.

PAYLOAD:
- Every in_valid word is payload regardless of its value; 16'hFFFF is data here. The matcher is held cleared while in PAYLOAD.
- Output latency is 1 cycle. In the cycle after an accepted word: fft_valid = 1 and fft_data = that word.
  - fft_start = 1 when pay_cnt was 0.
  - fft_last = 1 when pay_cnt was PAYLOAD_LEN-1.
- Once the last word is registered, go to WAIT_DONE with tmo_cnt = 0.
- If in_valid && !fft_ready on any payload word:
  - the word is not forwarded;
  - fft_abort pulses in the next cycle;
  - drop_cnt increments;
  - state returns to HUNT.
- fft_valid, fft_start and fft_last are 0 in any cycle without a forwarded word.

WAIT_DONE:
- fft_done causes frame_cnt to increment and state to go to HUNT.
- If a header completes in the same cycle as fft_done, the new frame is accepted: state goes to PAYLOAD.
- A header completing without fft_done counts as a dropped frame:
  - drop_cnt increments;
  - the payload that follows is ignored;
  - the matcher stays cleared for PAYLOAD_LEN valid words after the header.
- tmo_cnt increments each cycle. When it reaches DONE_TIMEOUT-1 without fft_done, timeout_err is set and state goes to HUNT.

fft_done outside WAIT_DONE is ignored.

Arithmetic: pay_cnt is 10 bits and tmo_cnt is 16 bits. Comparisons are unsigned.

Test Plan:
- Basic frame:
  - Stimulus: FFFF×3, then 0x0001..0x000A back-to-back with fft_ready=1, then fft_done 5 cycles later.
  - Required response: 10 fft_valid beats carrying 0x0001..0x000A, each 1 cycle after its input. fft_start on 0x0001, fft_last on 0x000A. frame_cnt = 1, busy falls after fft_done.
- Long header with gaps:
  - Stimulus: FFFF, idle, FFFF, FFFF, FFFF, then 9 further words.
  - Required response: the 4th FFFF is payload word 0 (fft_start with fft_data = FFFF).
  - Also: the sequence FFFF, FFFF, 0x1234, FFFF produces no frame.
- Back-pressure abort:
  - Stimulus: valid frame with fft_ready = 0 on payload word 4.
  - Required response: exactly 4 beats forwarded, fft_abort pulses once, drop_cnt = 1, the next header is accepted normally.
- Busy drop:
  - Stimulus: a second full header+payload during WAIT_DONE, with fft_done only after it.
  - Required response: no fft_valid for the second frame, drop_cnt = 1, frame_cnt = 1.
- Timeout:
  - Stimulus: DONE_TIMEOUT = 16, a frame with fft_done never asserted.
  - Required response: timeout_err rises 16 cycles after WAIT_DONE entry, state returns to HUNT, and a subsequent frame completes normally.
- Reset mid-payload:
  - Stimulus: rst asserted after 5 payload words.
  - Required response: all outputs 0 the next cycle, no fft_abort, counters 0, and a fresh frame after rst is forwarded correctly.
